// File: rtl/la_capture_pkg.sv
// Shared types and constants for the logic-analyzer RLE capture stage.
package la_capture_pkg;

  localparam int DATA_W    = 24;
  localparam int CNT_W     = 8;
  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int BT_LINES  = 24;
  localparam int LINE_W    = DATA_W + CNT_W;

  localparam logic [CNT_W-1:0]  MAX_REPS   = 8'hfd;
  localparam logic [CNT_W-1:0]  CNT_ZERO   = 8'h00;
  localparam logic [CNT_W-1:0]  CNT_ONE    = 8'h01;
  localparam logic [DATA_W-1:0] TRIG_MASK  = 24'h0f0000;
  localparam logic [DATA_W-1:0] TRIG_VALUE = 24'h030000;

  localparam logic [ADDR_W-1:0] PRE_FIRST     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PRE_LAST      = ADDR_W'(BT_LINES - 1);
  localparam logic [ADDR_W-1:0] TRIG_ADDR     = ADDR_W'(BT_LINES);
  localparam logic [ADDR_W-1:0] POST_LAST     = ADDR_W'(MEM_DEPTH - 2);
  localparam logic [ADDR_W-1:0] BOOKMARK_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
  } line_t;

  typedef enum logic [1:0] {
    PRE   = 2'd0,
    POST  = 2'd1,
    BMARK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // What the run-length stage does with the current sample.
  typedef enum logic [2:0] {
    ACT_IDLE   = 3'd0,
    ACT_OPEN   = 3'd1,
    ACT_EXTEND = 3'd2,
    ACT_CLOSE  = 3'd3,
    ACT_TRIG   = 3'd4
  } run_act_t;

  function automatic logic trig_hit(input logic [DATA_W-1:0] sample);
    return (sample & TRIG_MASK) == TRIG_VALUE;
  endfunction

  function automatic logic [ADDR_W-1:0] next_pre_addr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] nxt;
    if (addr == PRE_LAST) begin
      nxt = PRE_FIRST;
    end else begin
      nxt = addr + ADDR_W'(1);
    end
    return nxt;
  endfunction

  function automatic line_t bookmark_line(input logic [ADDR_W-1:0] bm);
    return line_t'({{(LINE_W - ADDR_W){1'b0}}, bm});
  endfunction

endpackage

// File: rtl/la_trigger_match.sv
// Registered trigger compare; one cycle of latency so match lines up with the sample register.
module la_trigger_match
  import la_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst_l,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample,
  output logic              match
);

  // Match flag register, cleared by reset or by a capture restart.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      match <= 1'b0;
    end else if (clear) begin
      match <= 1'b0;
    end else begin
      match <= trig_hit(sample);
    end
  end

endmodule

// File: rtl/la_rle_capture.sv
// Run-length capture stage: compresses probe samples into {data,count} lines for capture RAM,
// with a circular pre-trigger region, a linear post-trigger region and a trailing bookmark word.
module la_rle_capture
  import la_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst_l,
  input  logic [DATA_W-1:0] data_in,
  input  logic              arm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              la_trigger_matched,
  output logic              capture_done
);

  logic [DATA_W-1:0] s_r;
  logic              s_valid_r;
  logic [DATA_W-1:0] prev_r;
  logic [CNT_W-1:0]  run_cnt_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] bookmark_r;
  state_t            state_r;
  logic              match_s;
  run_act_t          act_s;
  line_t             closed_s;
  logic              last_post_s;

  la_trigger_match u_trig (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (arm),
    .sample (data_in),
    .match  (match_s)
  );

  assign closed_s    = {prev_r, run_cnt_r};
  assign last_post_s = (state_r == POST) && (act_s == ACT_CLOSE) && (wr_addr_r == POST_LAST);

  // Input sample register; s_valid_r keeps the reset value of s_r from opening a run.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s_r       <= 24'h000000;
      s_valid_r <= 1'b0;
    end else if (arm) begin
      s_r       <= 24'h000000;
      s_valid_r <= 1'b0;
    end else begin
      s_r       <= data_in;
      s_valid_r <= 1'b1;
    end
  end

  // Classify the current sample against the open run.
  always_comb begin
    act_s = ACT_IDLE;
    if (!s_valid_r) begin
      act_s = ACT_IDLE;
    end else if ((state_r == PRE) && match_s) begin
      act_s = ACT_TRIG;
    end else if ((state_r != PRE) && (state_r != POST)) begin
      act_s = ACT_IDLE;
    end else if (run_cnt_r == CNT_ZERO) begin
      act_s = ACT_OPEN;
    end else if ((s_r == prev_r) && (run_cnt_r < MAX_REPS)) begin
      act_s = ACT_EXTEND;
    end else begin
      act_s = ACT_CLOSE;
    end
  end

  // Open run register; a close always reopens on the sample that ended the run.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prev_r    <= 24'h000000;
      run_cnt_r <= CNT_ZERO;
    end else if (arm) begin
      prev_r    <= 24'h000000;
      run_cnt_r <= CNT_ZERO;
    end else if (last_post_s) begin
      run_cnt_r <= CNT_ZERO;
    end else begin
      case (act_s)
        ACT_OPEN, ACT_CLOSE, ACT_TRIG: begin
          prev_r    <= s_r;
          run_cnt_r <= CNT_ONE;
        end
        ACT_EXTEND: run_cnt_r <= run_cnt_r + CNT_ONE;
        default:    run_cnt_r <= run_cnt_r;
      endcase
    end
  end

  // Capture FSM with address generator, bookmark tracking and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r            <= PRE;
      wr_addr_r          <= PRE_FIRST;
      bookmark_r         <= PRE_LAST;
      mem_we             <= 1'b0;
      mem_addr           <= PRE_FIRST;
      mem_wdata          <= 32'h00000000;
      la_trigger_matched <= 1'b0;
      capture_done       <= 1'b0;
    end else if (arm) begin
      state_r            <= PRE;
      wr_addr_r          <= PRE_FIRST;
      bookmark_r         <= PRE_LAST;
      mem_we             <= 1'b0;
      mem_addr           <= PRE_FIRST;
      mem_wdata          <= 32'h00000000;
      la_trigger_matched <= 1'b0;
      capture_done       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state_r)
        PRE: begin
          case (act_s)
            ACT_TRIG: begin
              // A trigger on a fresh capture has no run to flush, so the bookmark stays put.
              if (run_cnt_r != CNT_ZERO) begin
                mem_we     <= 1'b1;
                mem_addr   <= wr_addr_r;
                mem_wdata  <= closed_s;
                bookmark_r <= wr_addr_r;
              end
              wr_addr_r          <= TRIG_ADDR;
              la_trigger_matched <= 1'b1;
              state_r            <= POST;
            end
            ACT_CLOSE: begin
              mem_we     <= 1'b1;
              mem_addr   <= wr_addr_r;
              mem_wdata  <= closed_s;
              bookmark_r <= wr_addr_r;
              wr_addr_r  <= next_pre_addr(wr_addr_r);
            end
            default: wr_addr_r <= wr_addr_r;
          endcase
        end
        POST: begin
          if (act_s == ACT_CLOSE) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr_r;
            mem_wdata <= closed_s;
            if (wr_addr_r == POST_LAST) begin
              state_r <= BMARK;
            end else begin
              wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end
          end
        end
        BMARK: begin
          mem_we    <= 1'b1;
          mem_addr  <= BOOKMARK_ADDR;
          mem_wdata <= bookmark_line(bookmark_r);
          state_r   <= DONE;
        end
        DONE: begin
          capture_done <= 1'b1;
        end
        default: state_r <= PRE;
      endcase
    end
  end

endmodule
